pattern_sweep_capture: RTL and testbench



---
 rtl/pattern_sweep_capture.sv | 143 ++++++++++++++
 tb/tb_pattern_sweep_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sweep_capture.sv
// Exhaustive input sweep generator with a valid/ready capture stream of {vector, response} pairs.
// Define SWEEP_MISR_EN to fold the sweep into a MISR signature; otherwise signature is tied to 0.
module pattern_sweep_capture #(
  parameter int unsigned N_WIDTH   = 8,
  parameter int unsigned OUT_WIDTH = 1,
  parameter int unsigned DWELL     = 1,
  parameter int unsigned SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0] SIG_POLY = 16'h1021
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  output logic [N_WIDTH-1:0]   N,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 cap_valid,
  input  logic                 cap_ready,
  output logic [N_WIDTH-1:0]   cap_vec,
  output logic [OUT_WIDTH-1:0] cap_resp,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StApply, StHold, StDone} state_e;

  state_e                state_q, state_d;
  logic [N_WIDTH:0]      idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [N_WIDTH-1:0]    cap_vec_q, cap_vec_d;
  logic [OUT_WIDTH-1:0]  cap_resp_q, cap_resp_d;
  logic [N_WIDTH-1:0]    idx_lo;
  logic [N_WIDTH-1:0]    vec;
  logic                  sweep_start;
  logic                  handshake;

  assign idx_lo = idx_q[N_WIDTH-1:0];

  always_comb begin
    case (mode_q)
      2'b01:   vec = idx_lo ^ (idx_lo >> 1);
      2'b10:   vec = ~idx_lo;
      default: vec = idx_lo;
    endcase
  end

  assign sweep_start = ((state_q == StIdle) || (state_q == StDone)) && start;
  assign handshake   = (state_q == StHold) && cap_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    cap_vec_d  = cap_vec_q;
    cap_resp_d = cap_resp_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mode_d  = mode;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StApply;
        end
      end
      StApply: begin
        if (cnt_q == CntLast) begin
          cap_vec_d  = vec;
          cap_resp_d = dut_out;
          cnt_d      = '0;
          state_d    = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cap_ready) begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_lo == '1) ? StDone : StApply;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= 2'b00;
      cap_vec_q  <= '0;
      cap_resp_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      cap_vec_q  <= cap_vec_d;
      cap_resp_q <= cap_resp_d;
    end
  end

  assign N         = vec;
  assign cap_valid = (state_q == StHold);
  assign cap_vec   = cap_vec_q;
  assign cap_resp  = cap_resp_q;
  assign busy      = (state_q == StApply) || (state_q == StHold);
  assign done      = (state_q == StDone);

`ifdef SWEEP_MISR_EN
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [SIG_WIDTH-1:0] pair_ext;

  always_comb begin
    pair_ext = '0;
    pair_ext[N_WIDTH+OUT_WIDTH-1:0] = {cap_vec_q, cap_resp_q};
    sig_d = sig_q;
    if (sweep_start) begin
      sig_d = '0;
    end else if (handshake) begin
      sig_d = (sig_q << 1) ^ (sig_q[SIG_WIDTH-1] ? SIG_POLY : '0) ^ pair_ext;
    end
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_pattern_sweep_capture.sv
// Directed bench for pattern_sweep_capture: binary/Gray/descending order, dwell, backpressure,
// mid-sweep reset, start handling and the MISR signature (with or without SWEEP_MISR_EN).
module tb_pattern_sweep_capture;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  // Instance A: N_WIDTH=2, DWELL=1, 4-bit MISR with polynomial 4'h3
  logic       a_reset, a_start, a_ready, a_zero;
  logic [1:0] a_mode, a_N, a_cap_vec;
  logic       a_dut_out, a_cap_valid, a_cap_resp, a_busy, a_done;
  logic [3:0] a_sig;

  assign a_dut_out = a_zero ? 1'b0 : a_N[0];

  pattern_sweep_capture #(
    .N_WIDTH(2), .OUT_WIDTH(1), .DWELL(1), .SIG_WIDTH(4), .SIG_POLY(4'h3)
  ) u_dut_a (
    .CK(CK), .reset(a_reset), .start(a_start), .mode(a_mode), .N(a_N), .dut_out(a_dut_out),
    .cap_valid(a_cap_valid), .cap_ready(a_ready), .cap_vec(a_cap_vec), .cap_resp(a_cap_resp),
    .busy(a_busy), .done(a_done), .signature(a_sig)
  );

  // Instance B: N_WIDTH=3, DWELL=3, Gray order
  logic        b_reset, b_start, b_ready;
  logic [1:0]  b_mode;
  logic [2:0]  b_N, b_cap_vec;
  logic        b_dut_out, b_cap_valid, b_cap_resp, b_busy, b_done;
  logic [15:0] b_sig;

  assign b_dut_out = b_N[1];

  pattern_sweep_capture #(
    .N_WIDTH(3), .OUT_WIDTH(1), .DWELL(3)
  ) u_dut_b (
    .CK(CK), .reset(b_reset), .start(b_start), .mode(b_mode), .N(b_N), .dut_out(b_dut_out),
    .cap_valid(b_cap_valid), .cap_ready(b_ready), .cap_vec(b_cap_vec), .cap_resp(b_cap_resp),
    .busy(b_busy), .done(b_done), .signature(b_sig)
  );

  int n_pass = 0;
  int n_checks = 0;
  int pv[$];
  int pr[$];
  logic stalled, found;
  logic [2:0] gray [8];
  logic [3:0] sig_zero_exp, sig_bin_exp;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_n"}, 32'(a_N), 0);
    check({tag, "_valid"}, 32'(a_cap_valid), 0);
    check({tag, "_vec"}, 32'(a_cap_vec), 0);
    check({tag, "_resp"}, 32'(a_cap_resp), 0);
    check({tag, "_busy"}, 32'(a_busy), 0);
    check({tag, "_done"}, 32'(a_done), 0);
    check({tag, "_sig"}, 32'(a_sig), 0);
  endtask

  task automatic check_pairs(input string tag, input int v0, input int v1, input int v2,
                             input int v3);
    int exp_v [4];
    exp_v = '{v0, v1, v2, v3};
    check({tag, "_count"}, 32'(pv.size()), 4);
    for (int i = 0; i < 4 && i < pv.size(); i++) begin
      check({tag, "_vec"}, 32'(pv[i]), 32'(exp_v[i]));
      check({tag, "_resp"}, 32'(pr[i]), 32'(exp_v[i] & 1));
    end
  endtask

  initial begin
    gray = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`ifdef SWEEP_MISR_EN
    sig_zero_exp = 4'h6;
    sig_bin_exp  = 4'h3;
`else
    sig_zero_exp = 4'h0;
    sig_bin_exp  = 4'h0;
`endif
    a_reset = 1'b1; a_start = 1'b0; a_ready = 1'b1; a_zero = 1'b0; a_mode = 2'b00;
    b_reset = 1'b1; b_start = 1'b0; b_ready = 1'b1; b_mode = 2'b00;
    tick();
    tick();
    a_reset = 1'b0;
    b_reset = 1'b0;
    check_a_reset("rst");

    // Binary order without stalls; dut_out follows N[0]
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("bin_busy", 32'(a_busy), 1);
    check("bin_n0", 32'(a_N), 0);
    pv.delete(); pr.delete();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (a_cap_valid) begin
        pv.push_back(int'(a_cap_vec));
        pr.push_back(int'(a_cap_resp));
      end
      if (k == 7) check("bin_done_early", 32'(a_done), 0);
    end
    check("bin_done", 32'(a_done), 1);
    check("bin_busy_end", 32'(a_busy), 0);
    check_pairs("bin", 0, 1, 2, 3);
    check("bin_sig", 32'(a_sig), 32'(sig_bin_exp));

    // Gray order, each vector held DWELL+1 = 4 cycles
    b_mode = 2'b01;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int j = 0; j < 32; j++) begin
      check("gray_n", 32'(b_N), 32'(gray[j / 4]));
      if (j % 4 == 3) begin
        check("gray_valid", 32'(b_cap_valid), 1);
        check("gray_capvec", 32'(b_cap_vec), 32'(gray[j / 4]));
      end
      tick();
    end
    check("gray_done", 32'(b_done), 1);

    // Backpressure: 5 stalled cycles on vector 2, starting from DONE
    a_mode = 2'b00;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("bp_done_clr", 32'(a_done), 0);
    stalled = 1'b0;
    pv.delete(); pr.delete();
    for (int c = 0; c < 40 && !a_done; c++) begin
      if (a_cap_valid && a_cap_vec == 2'd2 && !stalled) begin
        stalled = 1'b1;
        a_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("bp_valid", 32'(a_cap_valid), 1);
          check("bp_vec", 32'(a_cap_vec), 2);
          check("bp_resp", 32'(a_cap_resp), 0);
          check("bp_n", 32'(a_N), 2);
        end
        a_ready = 1'b1;
      end
      if (a_cap_valid && a_ready) begin
        pv.push_back(int'(a_cap_vec));
        pr.push_back(int'(a_cap_resp));
      end
      tick();
    end
    check("bp_stalled", 32'(stalled), 1);
    check("bp_done", 32'(a_done), 1);
    check_pairs("bp", 0, 1, 2, 3);
    check("bp_sig", 32'(a_sig), 32'(sig_bin_exp));

    // Reset (together with start) during HOLD of vector 1
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (a_cap_valid && a_cap_vec == 2'd1) found = 1'b1;
      else tick();
    end
    check("rst_found_hold1", 32'(found), 1);
    a_reset = 1'b1;
    a_start = 1'b1;
    tick();
    a_reset = 1'b0;
    a_start = 1'b0;
    check_a_reset("midrst");
    tick();
    check("midrst_idle", 32'(a_busy), 0);

    // Restart with dut_out tied low: MISR reference run
    a_zero = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("misr_busy", 32'(a_busy), 1);
    check("misr_n0", 32'(a_N), 0);
    check("misr_sig0", 32'(a_sig), 0);
    pv.delete(); pr.delete();
    for (int c = 0; c < 20 && !a_done; c++) begin
      tick();
      if (a_cap_valid) pv.push_back(int'(a_cap_vec));
    end
    check("misr_done", 32'(a_done), 1);
    check("misr_count", 32'(pv.size()), 4);
    if (pv.size() > 0) check("misr_first_vec", 32'(pv[0]), 0);
    check("misr_sig", 32'(a_sig), 32'(sig_zero_exp));

    // Descending restart from DONE; start pulses and mode changes mid-sweep are ignored
    a_zero = 1'b0;
    a_mode = 2'b10;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_mode = 2'b00;
    check("desc_done_clr", 32'(a_done), 0);
    check("desc_busy", 32'(a_busy), 1);
    check("desc_n0", 32'(a_N), 3);
    pv.delete(); pr.delete();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (a_cap_valid) begin
        pv.push_back(int'(a_cap_vec));
        pr.push_back(int'(a_cap_resp));
      end
      a_start = (k == 2 || k == 5);
      if (k == 7) check("desc_done_early", 32'(a_done), 0);
    end
    a_start = 1'b0;
    check("desc_done", 32'(a_done), 1);
    check_pairs("desc", 3, 2, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
